systolic_operand_feeder: RTL and testbench
==========================================

Name: systolic_operand_feeder

Overview:
- Upstream operand sequencer for the N x N output-stationary systolic array.
- Accepts A and B element-by-element over a valid/ready load stream and buffers one tile of each.
- Clears the array's accumulators, then presents N beats (A column k, B row k) on the array's matrix_a_in/matrix_b_in/valid_in.
- Waits for the array pipeline to drain, then pulses tile_done.
- Skew is not applied here; the array skews internally.

Parameters:
- DATA_SIZE, 8, operand element width in bits.
- N, 3, array dimension; tile is N x N.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ld_data  input  DATA_SIZE  operand element being loaded.
- ld_valid  input  1  ld_data valid.
- ld_ready  output  1  feeder accepts ld_data this cycle.
- matrix_a_out  output  DATA_SIZE*N  to array matrix_a_in; lane i at [i*DATA_SIZE +: DATA_SIZE] = A[i][k].
- matrix_b_out  output  DATA_SIZE*N  to array matrix_b_in; lane j = B[k][j].
- valid_out  output  1  to array valid_in; high during operand beats.
- arr_clear  output  1  one-cycle pulse, ORed into the array reset to zero its accumulators.
- busy  output  1  high in any state other than LOAD.
- tile_done  output  1  one-cycle pulse; array matrix_c_out holds the finished product.

Behaviour:
- Reset: state=LOAD, load counter=0, beat/flush counters=0.
- Reset values: matrix_a_out=0, matrix_b_out=0, valid_out=0, arr_clear=0, tile_done=0, busy=0.
- ld_ready = (state==LOAD) && !reset. Buffer contents need not be cleared by reset.
- Transfer: occurs on a rising edge when ld_valid && ld_ready.
- Load order: load index L counts 0..2*N*N-1.
  - L < N*N: A[L/N][L%N], row-major.
  - L >= N*N: B[(L-N*N)/N][(L-N*N)%N], row-major.
- ld_valid gaps are allowed; the counter advances only on a transfer.
- States:
  - LOAD: waits for data; moves to CLEAR on the edge that accepts L = 2*N*N-1.
  - CLEAR: 1 cycle; arr_clear=1, operands=0, valid_out=0. Next state STREAM.
  - STREAM: N cycles, k=0..N-1; valid_out=1; matrix_a_out lane i=A[i][k]; matrix_b_out lane j=B[k][j]. Next state FLUSH.
  - FLUSH: 2N-1 cycles; operands=0, valid_out=0. Covers skew (N-1) + hops (N-1) + the array output register. Next state DONE.
  - DONE: 1 cycle; tile_done=1. Next state LOAD, with L reset to 0.
- All outputs are registered functions of state and counters; none are combinational from ld_valid.
- Cycle timing for N=3, last load accepted at edge e:
  - arr_clear high in cycle e+1.
  - Beats in cycles e+2..e+4.
  - Flush in cycles e+5..e+9.
  - tile_done high in cycle e+10.
  - ld_ready high from cycle e+11.
- ld_valid asserted outside LOAD: ignored, no transfer, data not consumed.
- Reset mid-operation (any state): immediate return to LOAD with L=0. Partially loaded data is discarded and no tile_done is issued.
- Product width and overflow are the array's responsibility; the feeder passes operands unmodified.

Decomposition:
- Shared package:
  - State enum (LOAD, CLEAR, STREAM, FLUSH, DONE).
  - Localparams TILE_ELEMS=N*N, LOAD_BEATS=2*N*N, FLUSH_CYCLES=2*N-1.
  - Counter widths via $clog2.
- One sub-module, feeder_operand_buf:
  - Two N*N DATA_SIZE register banks with a single write port (index L).
  - Combinational read of A column k and B row k as packed N-lane vectors.
- FSM and counters stay in the top module.

Test Plan:
- Basic tile: load A=[[1,2,3],[4,5,6],[7,8,9]], B=I with continuous ld_valid. Expected beats:
  - k=0: matrix_a_out=0x070401, matrix_b_out=0x000001.
  - k=1: 0x080502, 0x000100.
  - k=2: 0x090603, 0x010000.
  - tile_done exactly 10 cycles after the last load edge.
- Integrated with the array, same stimulus: at tile_done, matrix_c_out equals A (16-bit lanes 1..9 in array order).
- Back-to-back tiles: tile 1 is A·I, tile 2 is A·(2I). Second result lanes must be 2,4,...,18, not accumulated; confirms arr_clear pulses once per tile in the CLEAR cycle.
- Load backpressure and gaps: random ld_valid gaps in LOAD all accepted in order. ld_valid held high through STREAM/FLUSH must show ld_ready=0, and no element may be consumed before DONE.
- Reset during the second STREAM beat: next cycle all outputs are 0, state is LOAD, ld_ready=1. A fresh full load then produces correct beats with no stale data.
- Timing invariants, all tiles: valid_out high for exactly N consecutive cycles per tile; busy low only in LOAD.

Source files
------------

// File: rtl/systolic_operand_feeder_pkg.sv
// Shared types and sizing helpers for the systolic operand feeder.
// Localparams below describe the default 3x3 tile; the helpers size any N.
package systolic_operand_feeder_pkg;

  typedef enum logic [2:0] {
    LOAD,
    CLEAR,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_e;

  localparam int unsigned DEF_N         = 3;
  localparam int unsigned DEF_DATA_SIZE = 8;

  function automatic int unsigned tile_elems(input int unsigned n);
    return n * n;
  endfunction

  function automatic int unsigned load_beats(input int unsigned n);
    return 2 * n * n;
  endfunction

  // Skew (n-1) plus hops (n-1) plus the array's output register.
  function automatic int unsigned flush_cycles(input int unsigned n);
    return 2 * n - 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int unsigned TILE_ELEMS   = tile_elems(DEF_N);
  localparam int unsigned LOAD_BEATS   = load_beats(DEF_N);
  localparam int unsigned FLUSH_CYCLES = flush_cycles(DEF_N);
  localparam int unsigned LOAD_CNT_W   = cnt_width(LOAD_BEATS);
  localparam int unsigned BEAT_CNT_W   = cnt_width(DEF_N);
  localparam int unsigned FLUSH_CNT_W  = cnt_width(FLUSH_CYCLES);

endpackage

// File: rtl/systolic_operand_feeder_buf.sv
// Tile buffer for the operand feeder: A and B banks share one write port
// addressed by the load index; reads return A column k and B row k.
module feeder_operand_buf
  import systolic_operand_feeder_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned N         = DEF_N,
  parameter int unsigned IDX_W     = cnt_width(load_beats(N)),
  parameter int unsigned K_W       = cnt_width(N)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [DATA_SIZE-1:0]   wr_data,
  input  logic [K_W-1:0]         rd_k,
  output logic [DATA_SIZE*N-1:0] a_col,
  output logic [DATA_SIZE*N-1:0] b_row
);

  localparam int unsigned TILE = tile_elems(N);

  logic [TILE*DATA_SIZE-1:0] a_mem_q, a_mem_d;
  logic [TILE*DATA_SIZE-1:0] b_mem_q, b_mem_d;

  // Indices below TILE land in A, the rest in B, both row-major.
  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    for (int e = 0; e < TILE; e++) begin
      if (wr_en && (wr_idx == IDX_W'(e)))
        a_mem_d[e*DATA_SIZE +: DATA_SIZE] = wr_data;
      if (wr_en && (wr_idx == IDX_W'(e + TILE)))
        b_mem_d[e*DATA_SIZE +: DATA_SIZE] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    a_mem_q <= a_mem_d;
    b_mem_q <= b_mem_d;
  end

  always_comb begin
    a_col = '0;
    b_row = '0;
    for (int k = 0; k < N; k++) begin
      if (rd_k == K_W'(k)) begin
        for (int i = 0; i < N; i++) begin
          a_col[i*DATA_SIZE +: DATA_SIZE] = a_mem_q[(i*N+k)*DATA_SIZE +: DATA_SIZE];
          b_row[i*DATA_SIZE +: DATA_SIZE] = b_mem_q[(k*N+i)*DATA_SIZE +: DATA_SIZE];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Operand sequencer for an N x N output-stationary systolic array: buffers a
// tile of A and B, clears the array, streams N beats, waits for drain.
module systolic_operand_feeder
  import systolic_operand_feeder_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned N         = DEF_N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_SIZE-1:0]   ld_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  output logic [DATA_SIZE*N-1:0] matrix_a_out,
  output logic [DATA_SIZE*N-1:0] matrix_b_out,
  output logic                   valid_out,
  output logic                   arr_clear,
  output logic                   busy,
  output logic                   tile_done
);

  localparam int unsigned NUM_LOADS = load_beats(N);
  localparam int unsigned NUM_FLUSH = flush_cycles(N);
  localparam int unsigned LD_W      = cnt_width(NUM_LOADS);
  localparam int unsigned BEAT_W    = cnt_width(N);
  localparam int unsigned FL_W      = cnt_width(NUM_FLUSH);

  feeder_state_e     state_q, state_d;
  logic [LD_W-1:0]   load_cnt_q, load_cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [FL_W-1:0]   flush_q, flush_d;
  logic              ld_xfer;
  logic [DATA_SIZE*N-1:0] a_col, b_row;

  assign ld_ready = (state_q == LOAD) && !reset;
  assign ld_xfer  = ld_valid && ld_ready;

  feeder_operand_buf #(
    .DATA_SIZE (DATA_SIZE),
    .N         (N),
    .IDX_W     (LD_W),
    .K_W       (BEAT_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (ld_xfer),
    .wr_idx  (load_cnt_q),
    .wr_data (ld_data),
    .rd_k    (beat_q),
    .a_col   (a_col),
    .b_row   (b_row)
  );

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    beat_d     = beat_q;
    flush_d    = flush_q;
    case (state_q)
      LOAD: begin
        if (ld_xfer) begin
          if (load_cnt_q == LD_W'(NUM_LOADS - 1)) begin
            load_cnt_d = '0;
            state_d    = CLEAR;
          end else begin
            load_cnt_d = load_cnt_q + LD_W'(1);
          end
        end
      end
      CLEAR: begin
        beat_d  = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (beat_q == BEAT_W'(N - 1)) begin
          beat_d  = '0;
          flush_d = '0;
          state_d = FLUSH;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      FLUSH: begin
        if (flush_q == FL_W'(NUM_FLUSH - 1)) begin
          flush_d = '0;
          state_d = DONE;
        end else begin
          flush_d = flush_q + FL_W'(1);
        end
      end
      DONE: begin
        load_cnt_d = '0;
        state_d    = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD;
      load_cnt_q <= '0;
      beat_q     <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      beat_q     <= beat_d;
      flush_q    <= flush_d;
    end
  end

  // Outputs decode only registered state, so ld_valid never reaches them.
  assign valid_out    = (state_q == STREAM);
  assign matrix_a_out = valid_out ? a_col : '0;
  assign matrix_b_out = valid_out ? b_row : '0;
  assign arr_clear    = (state_q == CLEAR);
  assign tile_done    = (state_q == DONE);
  assign busy         = (state_q != LOAD);

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Randomized self-checking bench: tiles are loaded from a matrix model and the
// expected beat/timing trace is derived from the matrices and tile schedule.
module tb_systolic_operand_feeder;

  localparam int N     = 3;
  localparam int DS    = 8;
  localparam int NN    = N * N;
  localparam int TOTAL = 2 * NN;
  localparam int WIN   = 3 * N + 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [DS-1:0]   ld_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [DS*N-1:0] matrix_a_out;
  logic [DS*N-1:0] matrix_b_out;
  logic            valid_out;
  logic            arr_clear;
  logic            busy;
  logic            tile_done;

  int numChecks = 0;
  int numFails  = 0;

  logic [DS-1:0] tileA [N][N];
  logic [DS-1:0] tileB [N][N];

  systolic_operand_feeder #(.DATA_SIZE(DS), .N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .matrix_a_out (matrix_a_out),
    .matrix_b_out (matrix_b_out),
    .valid_out    (valid_out),
    .arr_clear    (arr_clear),
    .busy         (busy),
    .tile_done    (tile_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DS*N-1:0] expA(input int k);
    logic [DS*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*DS +: DS] = tileA[i][k];
    return r;
  endfunction

  function automatic logic [DS*N-1:0] expB(input int k);
    logic [DS*N-1:0] r;
    for (int j = 0; j < N; j++) r[j*DS +: DS] = tileB[k][j];
    return r;
  endfunction

  task automatic randomTile();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tileA[i][j] = 8'($urandom);
        tileB[i][j] = 8'($urandom);
      end
  endtask

  // Entered at a negedge; returns just after the edge accepting the last element.
  task automatic applyStimulus(input int count, input bit gaps);
    for (int l = 0; l < count; l++) begin
      int waited;
      logic [DS-1:0] v;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ld_valid = 1'b0;
          @(negedge clk);
        end
      end
      v = (l < NN) ? tileA[l / N][l % N] : tileB[(l - NN) / N][(l - NN) % N];
      ld_valid = 1'b1;
      ld_data  = v;
      waited   = 0;
      while (!ld_ready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("ld_ready_load", 64'(ld_ready), 64'd1);
      @(posedge clk);
      if (l != count - 1) @(negedge clk);
    end
  endtask

  // Cycle c after the last load edge: 1 clear, 2..N+1 beats, then flush, done, load.
  task automatic runTileWindow(input bit hold, input int cycles);
    for (int c = 1; c <= cycles; c++) begin
      bit isBeat, exClear, exDone, exLoad;
      int k;
      @(negedge clk);
      isBeat  = (c >= 2) && (c <= N + 1);
      k       = isBeat ? c - 2 : 0;
      exClear = (c == 1);
      exDone  = (c == 3 * N + 1);
      exLoad  = (c == 3 * N + 2);
      checkOutput("arr_clear", 64'(arr_clear), 64'(exClear));
      checkOutput("valid_out", 64'(valid_out), 64'(isBeat));
      checkOutput("tile_done", 64'(tile_done), 64'(exDone));
      checkOutput("busy", 64'(busy), 64'(!exLoad));
      checkOutput("ld_ready", 64'(ld_ready), 64'(exLoad));
      checkOutput("matrix_a_out", 64'(matrix_a_out), isBeat ? 64'(expA(k)) : 64'd0);
      checkOutput("matrix_b_out", 64'(matrix_b_out), isBeat ? 64'(expB(k)) : 64'd0);
      if (hold && !exLoad) begin
        ld_valid = 1'b1;
        ld_data  = 8'($urandom);
      end else begin
        ld_valid = 1'b0;
      end
    end
  endtask

  task automatic checkIdle(input string tag, input bit exReady);
    checkOutput({tag, "_ld_ready"}, 64'(ld_ready), 64'(exReady));
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_valid"}, 64'(valid_out), 64'd0);
    checkOutput({tag, "_clear"}, 64'(arr_clear), 64'd0);
    checkOutput({tag, "_done"}, 64'(tile_done), 64'd0);
    checkOutput({tag, "_a"}, 64'(matrix_a_out), 64'd0);
    checkOutput({tag, "_b"}, 64'(matrix_b_out), 64'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset    = 1'b1;
    ld_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    ld_valid = 1'b0;
    ld_data  = '0;
    repeat (2) @(negedge clk);
    checkIdle("reset", 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkIdle("post_reset", 1'b1);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        tileA[i][j] = 8'(i * N + j + 1);
        tileB[i][j] = (i == j) ? 8'd1 : 8'd0;
      end
    $display("[TB] tile 1: A x I, continuous load");
    applyStimulus(TOTAL, 1'b0);
    runTileWindow(1'b0, WIN);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) tileB[i][j] = (i == j) ? 8'd2 : 8'd0;
    $display("[TB] tile 2: A x 2I, ld_valid held while busy");
    applyStimulus(TOTAL, 1'b0);
    runTileWindow(1'b1, WIN);

    $display("[TB] tile 3: random with gaps");
    randomTile();
    applyStimulus(TOTAL, 1'b1);
    runTileWindow(1'b1, WIN);

    $display("[TB] tile 4: reset during second beat");
    randomTile();
    applyStimulus(TOTAL, 1'b1);
    runTileWindow(1'b0, 3);
    reset    = 1'b1;
    ld_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkIdle("stream_reset", 1'b1);

    $display("[TB] partial load then reset");
    randomTile();
    applyStimulus(5, 1'b1);
    pulseReset();
    checkIdle("partial_reset", 1'b1);

    $display("[TB] tile 5: fresh full load after reset");
    randomTile();
    applyStimulus(TOTAL, 1'b1);
    runTileWindow(1'b1, WIN);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
